// File: rtl/mandel_line_scheduler.sv
// rtl/mandel_line_scheduler.sv - dispatches one line of pixels to the iteration engines and serialises their depths
module mandel_line_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int X_SIZE      = 640,
    parameter int XW          = 10,
    parameter int DEPTH_W     = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [NUM_ENGINES-1:0]       eng_start,
    output logic [NUM_ENGINES*XW-1:0]    eng_x,
    input  logic [NUM_ENGINES-1:0]       eng_done,
    input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
    output logic                         wr_en,
    output logic [XW-1:0]                wr_addr,
    output logic [DEPTH_W-1:0]           wr_data,
    output logic                         line_done,
    output logic                         busy,
    output logic                         err
);

    localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [XW:0] X_END = (XW+1)'(X_SIZE);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]                          state_q, state_d;
    logic [XW:0]                         next_x_q, next_x_d;
    logic [XW:0]                         written_q, written_d;
    logic [PW-1:0]                       rr_ptr_q, rr_ptr_d;
    logic [NUM_ENGINES-1:0]              assigned_q, assigned_d;
    logic [NUM_ENGINES-1:0]              pending_q, pending_d;
    logic [NUM_ENGINES-1:0][XW-1:0]      tag_q, tag_d;
    logic [NUM_ENGINES-1:0][XW-1:0]      eng_x_q, eng_x_d;
    logic [NUM_ENGINES-1:0][DEPTH_W-1:0] hold_q, hold_d;
    logic [NUM_ENGINES-1:0]              eng_start_q, eng_start_d;
    logic                                wr_en_q, wr_en_d;
    logic [XW-1:0]                       wr_addr_q, wr_addr_d;
    logic [DEPTH_W-1:0]                  wr_data_q, wr_data_d;
    logic                                err_q, err_d;

    logic                                accept;
    logic [XW:0]                         base_x;
    logic [XW:0]                         base_written;
    logic                                free_found;
    logic [PW-1:0]                       free_idx;
    logic                                grant_found;
    logic [PW-1:0]                       grant_idx;
    logic                                spurious;

    // Lowest-index engine that neither owns a pixel nor holds an unwritten result.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (!free_found && !assigned_q[i] && !pending_q[i]) begin
                free_found = 1'b1;
                free_idx   = PW'(i);
            end
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            if (!grant_found && pending_q[(int'(rr_ptr_q) + k) % NUM_ENGINES]) begin
                grant_found = 1'b1;
                grant_idx   = PW'((int'(rr_ptr_q) + k) % NUM_ENGINES);
            end
        end
    end

    always_comb begin
        accept       = (state_q == S_IDLE) && start;
        base_x       = accept ? '0 : next_x_q;
        base_written = accept ? '0 : written_q;
        spurious     = |(eng_done & ~assigned_q);

        state_d     = state_q;
        next_x_d    = base_x;
        written_d   = base_written;
        rr_ptr_d    = rr_ptr_q;
        assigned_d  = assigned_q;
        pending_d   = pending_q;
        tag_d       = tag_q;
        eng_x_d     = eng_x_q;
        hold_d      = hold_q;
        eng_start_d = '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_d       = (accept ? 1'b0 : err_q) | spurious;

        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (written_q == X_END) state_d = S_FLUSH;
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Dispatch on the same edge that accepts start so the first launch lands one cycle later.
        if ((accept || state_q == S_RUN) && (base_x < X_END) && free_found) begin
            eng_start_d[free_idx] = 1'b1;
            eng_x_d[free_idx]     = base_x[XW-1:0];
            tag_d[free_idx]       = base_x[XW-1:0];
            assigned_d[free_idx]  = 1'b1;
            next_x_d              = base_x + 1'b1;
        end

        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (eng_done[i] && assigned_q[i]) begin
                hold_d[i]     = eng_depth[i*DEPTH_W +: DEPTH_W];
                pending_d[i]  = 1'b1;
                assigned_d[i] = 1'b0;
            end
        end

        // Capture, dispatch and grant always touch disjoint engines, so their updates never collide.
        if (grant_found) begin
            wr_en_d              = 1'b1;
            wr_addr_d            = tag_q[grant_idx];
            wr_data_d            = hold_q[grant_idx];
            pending_d[grant_idx] = 1'b0;
            written_d            = base_written + 1'b1;
            rr_ptr_d             = PW'((int'(grant_idx) + 1) % NUM_ENGINES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            next_x_q    <= '0;
            written_q   <= '0;
            rr_ptr_q    <= '0;
            assigned_q  <= '0;
            pending_q   <= '0;
            tag_q       <= '0;
            eng_x_q     <= '0;
            hold_q      <= '0;
            eng_start_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_x_q    <= next_x_d;
            written_q   <= written_d;
            rr_ptr_q    <= rr_ptr_d;
            assigned_q  <= assigned_d;
            pending_q   <= pending_d;
            tag_q       <= tag_d;
            eng_x_q     <= eng_x_d;
            hold_q      <= hold_d;
            eng_start_q <= eng_start_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
        end
    end

    assign eng_start = eng_start_q;
    assign eng_x     = eng_x_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign line_done = (state_q == S_FLUSH);
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_mandel_line_scheduler.sv
// tb/tb_mandel_line_scheduler.sv - directed vector table plus engine-model line runs for mandel_line_scheduler
module tb_mandel_line_scheduler;

    localparam int N  = 4;
    localparam int XS = 640;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [N-1:0]  eng_start;
    logic [N*10-1:0] eng_x;
    logic [N-1:0]  eng_done;
    logic [N*10-1:0] eng_depth;
    logic          wr_en;
    logic [9:0]    wr_addr;
    logic [9:0]    wr_data;
    logic          line_done;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    mandel_line_scheduler #(.NUM_ENGINES(N), .X_SIZE(XS), .XW(10), .DEPTH_W(10)) dut (
        .clk(clk), .reset(reset), .start(start),
        .eng_start(eng_start), .eng_x(eng_x),
        .eng_done(eng_done), .eng_depth(eng_depth),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .line_done(line_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [3:0]  done;
        logic [39:0] depth;
        logic [3:0]  x_start;
        logic [9:0]  x_val;
        logic        wr;
        logic [9:0]  addr;
        logic [9:0]  data;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_eng_start"}, 64'(eng_start), 64'd0);
        chk({tag, "_eng_x"},     64'(eng_x),     64'd0);
        chk({tag, "_wr_en"},     64'(wr_en),     64'd0);
        chk({tag, "_wr_addr"},   64'(wr_addr),   64'd0);
        chk({tag, "_wr_data"},   64'(wr_data),   64'd0);
        chk({tag, "_line_done"}, 64'(line_done), 64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    // Engine model: depth = x + 3 after a fixed or random latency; scoreboard checks each address once.
    task automatic run_line(input bit rand_lat, input bit in_order, input int abort_at);
        int  cnt[N];
        int  xo[N];
        bit  seen[XS];
        int  nwr, cyc, last_wr, exp_addr;
        bit  finished;
        for (int i = 0; i < N; i++) begin cnt[i] = 0; xo[i] = 0; end
        for (int a = 0; a < XS; a++) seen[a] = 1'b0;
        nwr = 0; cyc = 0; last_wr = -10; exp_addr = 0; finished = 1'b0;
        start = 1'b1;
        while (!finished && cyc < 60000) begin
            step();
            start    = 1'b0;
            eng_done = '0;
            cyc++;
            if (cyc == 1) chk("err_cleared_by_start", 64'(err), 64'd0);
            if (wr_en) begin
                chk("wr_data_matches_addr", 64'(wr_data), 64'((wr_addr + 10'd3)));
                chk("addr_written_once", 64'(seen[wr_addr]), 64'd0);
                if (in_order) begin
                    chk("wr_addr_in_order", 64'(wr_addr), 64'(exp_addr));
                    exp_addr++;
                end
                seen[wr_addr] = 1'b1;
                nwr++;
                last_wr = cyc;
                if (abort_at != 0 && nwr == abort_at) return;
            end
            if (line_done) begin
                chk("line_done_after_last_write", 64'(cyc), 64'(last_wr + 1));
                chk("write_count", 64'(nwr), 64'(XS));
                chk("busy_during_flush", 64'(busy), 64'd1);
                step();
                chk("line_done_single_pulse", 64'(line_done), 64'd0);
                chk("busy_falls", 64'(busy), 64'd0);
                chk("err_after_line", 64'(err), 64'd0);
                finished = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (eng_start[i]) begin
                    cnt[i] = rand_lat ? int'($urandom_range(200, 1)) : 5;
                    xo[i]  = int'(eng_x[i*10 +: 10]);
                end
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        eng_done[i] = 1'b1;
                        eng_depth[i*10 +: 10] = 10'(xo[i] + 3);
                    end
                end
            end
        end
        if (!finished) chk("line_timeout", 64'd1, 64'd0);
    endtask

    task automatic reset_then_spurious(input string tag);
        #2 reset = 1'b1;
        #1;
        chk_all_zero(tag);
        chk({tag, "_err_zero"}, 64'(err), 64'd0);
        step();
        #3 reset = 1'b0;
        step();
        eng_done = 4'b0100;
        step();
        eng_done = '0;
        chk({tag, "_spurious_err"}, 64'(err), 64'd1);
        chk({tag, "_spurious_no_wr"}, 64'(wr_en), 64'd0);
        chk({tag, "_spurious_no_launch"}, 64'(eng_start), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; eng_done = '0; eng_depth = '0;

        //              start done     depth                                    x_start x   wr addr data
        tbl[0]  = '{1'b1, 4'b0000, 40'd0,                                   4'b0001, 10'd0,  1'b0, 10'd0, 10'd0};
        tbl[1]  = '{1'b0, 4'b0000, 40'd0,                                   4'b0010, 10'd1,  1'b0, 10'd0, 10'd0};
        tbl[2]  = '{1'b0, 4'b0000, 40'd0,                                   4'b0100, 10'd2,  1'b0, 10'd0, 10'd0};
        tbl[3]  = '{1'b0, 4'b0000, 40'd0,                                   4'b1000, 10'd3,  1'b0, 10'd0, 10'd0};
        tbl[4]  = '{1'b1, 4'b0000, 40'd0,                                   4'b0000, 10'd0,  1'b0, 10'd0, 10'd0};
        tbl[5]  = '{1'b0, 4'b1111, {10'd23, 10'd22, 10'd21, 10'd20},        4'b0000, 10'd0,  1'b0, 10'd0, 10'd0};
        tbl[6]  = '{1'b0, 4'b0000, 40'd0,                                   4'b0000, 10'd0,  1'b1, 10'd0, 10'd20};
        tbl[7]  = '{1'b0, 4'b0000, 40'd0,                                   4'b0001, 10'd4,  1'b1, 10'd1, 10'd21};
        tbl[8]  = '{1'b0, 4'b0000, 40'd0,                                   4'b0010, 10'd5,  1'b1, 10'd2, 10'd22};
        tbl[9]  = '{1'b0, 4'b0000, 40'd0,                                   4'b0100, 10'd6,  1'b1, 10'd3, 10'd23};
        tbl[10] = '{1'b0, 4'b0000, 40'd0,                                   4'b1000, 10'd7,  1'b0, 10'd0, 10'd0};
        tbl[11] = '{1'b0, 4'b1111, {10'd33, 10'd32, 10'd31, 10'd30},        4'b0000, 10'd0,  1'b0, 10'd0, 10'd0};
        tbl[12] = '{1'b0, 4'b0000, 40'd0,                                   4'b0000, 10'd0,  1'b1, 10'd4, 10'd30};
        tbl[13] = '{1'b0, 4'b0000, 40'd0,                                   4'b0001, 10'd8,  1'b1, 10'd5, 10'd31};
        tbl[14] = '{1'b0, 4'b0000, 40'd0,                                   4'b0010, 10'd9,  1'b1, 10'd6, 10'd32};
        tbl[15] = '{1'b0, 4'b0000, 40'd0,                                   4'b0100, 10'd10, 1'b1, 10'd7, 10'd33};
        tbl[16] = '{1'b0, 4'b0000, 40'd0,                                   4'b1000, 10'd11, 1'b0, 10'd0, 10'd0};

        #2;
        chk_all_zero("reset");
        chk("reset_err", 64'(err), 64'd0);
        #20 reset = 1'b0;
        step();

        for (int r = 0; r < 17; r++) begin
            start     = tbl[r].start;
            eng_done  = tbl[r].done;
            eng_depth = tbl[r].depth;
            step();
            start    = 1'b0;
            eng_done = '0;
            chk($sformatf("vec%0d_eng_start", r), 64'(eng_start), 64'(tbl[r].x_start));
            for (int i = 0; i < N; i++)
                if (tbl[r].x_start[i]) chk($sformatf("vec%0d_eng_x", r), 64'(eng_x[i*10 +: 10]), 64'(tbl[r].x_val));
            chk($sformatf("vec%0d_wr_en", r), 64'(wr_en), 64'(tbl[r].wr));
            if (tbl[r].wr) begin
                chk($sformatf("vec%0d_wr_addr", r), 64'(wr_addr), 64'(tbl[r].addr));
                chk($sformatf("vec%0d_wr_data", r), 64'(wr_data), 64'(tbl[r].data));
            end
            chk($sformatf("vec%0d_busy", r), 64'(busy), 64'd1);
            chk($sformatf("vec%0d_err", r), 64'(err), 64'd0);
            chk($sformatf("vec%0d_line_done", r), 64'(line_done), 64'd0);
        end

        reset_then_spurious("rst_tbl");
        run_line(1'b0, 1'b1, 0);
        run_line(1'b1, 1'b0, 100);
        reset_then_spurious("rst_100");
        run_line(1'b1, 1'b0, 0);

        step();
        eng_done = 4'b1000;
        step();
        eng_done = '0;
        chk("idle_done3_err", 64'(err), 64'd1);
        chk("idle_done3_no_wr", 64'(wr_en), 64'd0);
        chk("idle_done3_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
